fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Instruction-fetch controller sitting between the PC/branch logic and the synchronous instruction memory.
- It generates fetch addresses and tracks the 1-cycle read latency of the memory.
- Returned words are buffered in a 2-entry FIFO and presented to decode over a valid/ready handshake.
- On a redirect it discards all in-flight and buffered fetches and restarts fetching at the new target.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset (must be 4-byte aligned).

Ports:
I_clk  input  1  clock; all state updates on posedge.
I_reset  input  1  synchronous, active-high reset.
O_imem_address  output  32  byte address presented to instruction memory.
I_imem_data  input  32  memory read data; valid the cycle after the address is sampled.
I_redirect  input  1  one-cycle pulse: restart fetch at I_redirect_pc.
I_redirect_pc  input  32  redirect target byte address.
O_valid  output  1  head-of-buffer instruction is valid.
I_ready  input  1  decode accepts the head entry this cycle.
O_instr  output  32  head instruction word.
O_pc  output  32  byte address of O_instr.
O_misaligned  output  1  registered one-cycle pulse: the last redirect target had bits [1:0] != 0.

Behaviour:
- State:
  - fpc: 32-bit next fetch PC.
  - inflight_q: 1 bit.
  - inflight_pc_q: 32 bits.
  - 2-entry FIFO of {pc, instr}, with rd/wr pointers and a 2-bit count.
  - misaligned_q: 1 bit.
- Reset (synchronous, I_reset=1 at posedge):
  - fpc <= RESET_PC; inflight_q, count, pointers and misaligned_q cleared.
  - Therefore O_valid=0 and O_misaligned=0. O_instr and O_pc are don't-care while O_valid=0.
  - While I_reset=1, O_imem_address = RESET_PC.
  - Reset mid-operation drops all buffered and in-flight data.
- pop = O_valid & I_ready & ~I_redirect.
- Issue rule (normal cycle): issue when (count + inflight_q − pop) < 2.
  - This guarantees a returning word always has a free FIFO slot.
- O_imem_address:
  - Combinational; equals {I_redirect_pc[31:2],2'b00} when I_redirect=1, otherwise fpc.
  - The memory reads every cycle; results are used only when inflight_q=1.
- On issue (normal cycle): inflight_q <= 1, inflight_pc_q <= fpc, fpc <= fpc + 4.
  - Modulo 2^32: 0xFFFF_FFFC wraps to 0x0000_0000.
- On no issue: inflight_q <= 0; fpc holds.
- Return: when inflight_q=1 and I_redirect=0, push {inflight_pc_q, I_imem_data} into the FIFO.
  - Push and pop in the same cycle are permitted; count is unchanged in that case.
- Outputs:
  - O_valid = (count != 0).
  - O_instr / O_pc come from the FIFO head and are held stable while O_valid=1 and I_ready=0.
- Latency and throughput:
  - The first word after reset deassertion (cycle 0 = first cycle with I_reset=0) issues in cycle 0, is captured at the end of cycle 1, and O_valid=1 in cycle 2.
  - With I_ready held at 1, one instruction per cycle is sustained.
- Redirect (I_redirect=1 in cycle r), which takes priority over everything:
  - FIFO flushed (count <= 0) and the returning in-flight word is dropped.
  - Any handshake in cycle r does not count as a pop.
  - Aligned target issued in cycle r: inflight_q <= 1, inflight_pc_q <= aligned target, fpc <= aligned target + 4.
  - Result: O_valid=0 in cycle r+1; target instruction appears in cycle r+2.
  - misaligned_q <= (I_redirect_pc[1:0] != 0), so O_misaligned is high in cycle r+1 only; it is cleared the next cycle unless another misaligned redirect occurs.
- Back-to-back redirects: the latest one wins; each flushes the effect of the previous.
- Redirect together with I_reset: reset wins.
- FIFO full (count=2): no issue and no data loss; the FIFO can never overflow under the issue rule.
  - A verification assertion must check that a push never occurs with count=2 and no pop.

Test Plan:
1. Sequential fetch from reset:
   - Stimulus: RESET_PC=0x100; mem[0x100..]=0xA0,0xA1,0xA2; I_ready=1; deassert reset.
   - Required: O_valid rises in cycle 2 with O_pc=0x100, O_instr=0xA0; then 0x104/0xA1 and 0x108/0xA2 on consecutive cycles.
2. Backpressure:
   - Stimulus: hold I_ready=0 from cycle 2 for 5 cycles.
   - Required: O_pc stays 0x100 and count saturates at 2 with no further issue.
   - On release: 0x100, 0x104, 0x108 delivered back-to-back with no gap, duplicate or loss.
3. Redirect with full FIFO:
   - Stimulus: pulse I_redirect with I_redirect_pc=0x40 in cycle r.
   - Required: O_imem_address=0x40 in r; O_valid=0 in r+1; O_pc=0x40 in r+2; 0x44 in r+3; stale entries never appear.
4. Misaligned redirect:
   - Stimulus: I_redirect_pc=0x46.
   - Required: fetch address 0x44; O_misaligned=1 only in r+1; O_pc=0x44 in r+2.
5. Wrap-around:
   - Stimulus: redirect to 0xFFFF_FFFC with I_ready=1.
   - Required: O_pc sequence 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004.
6. Reset mid-operation:
   - Stimulus: assert I_reset for 1 cycle with FIFO full and a word in flight.
   - Required: O_valid=0 the next cycle; fetch resumes at RESET_PC; O_pc=RESET_PC two cycles after deassertion; no pre-reset words emerge.

Source files
------------

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
// Instruction-fetch controller between the PC/branch logic and a synchronous
// instruction memory with a 1-cycle read latency. It issues fetch addresses,
// tracks the single in-flight read, buffers returned words in a 2-entry FIFO
// and presents them to decode over a valid/ready handshake. A redirect
// flushes everything buffered or in flight and restarts at the new target.
//
// Ports:
//   I_clk, I_reset         clock, synchronous active-high reset
//   O_imem_address         byte address presented to instruction memory
//   I_imem_data            memory read data (cycle after address sampled)
//   I_redirect/_pc         one-cycle restart pulse and its target address
//   O_valid/I_ready        decode handshake for the FIFO head
//   O_instr, O_pc          head instruction word and its byte address
//   O_misaligned           one-cycle pulse: last redirect target unaligned
// ---------------------------------------------------------------------------
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        I_clk,
  input  logic        I_reset,
  output logic [31:0] O_imem_address,
  input  logic [31:0] I_imem_data,
  input  logic        I_redirect,
  input  logic [31:0] I_redirect_pc,
  output logic        O_valid,
  input  logic        I_ready,
  output logic [31:0] O_instr,
  output logic [31:0] O_pc,
  output logic        O_misaligned
);

  logic [31:0] fpc_q, fpc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic [31:0] fifo_pc_q    [2];
  logic [31:0] fifo_instr_q [2];
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  count_q, count_d;
  logic        misaligned_q, misaligned_d;

  logic        pop_s;
  logic        push_s;
  logic        issue_s;
  logic [2:0]  occupancy_s;
  logic [31:0] target_s;

  assign target_s = {I_redirect_pc[31:2], 2'b00};
  assign O_valid  = (count_q != 2'd0);
  assign pop_s    = O_valid & I_ready & ~I_redirect;
  assign push_s   = inflight_q & ~I_redirect;

  // Slots already committed (buffered + in flight) after this cycle's pop.
  // Issuing only while this is below 2 guarantees every returning word has
  // a free FIFO slot. pop implies count >= 1, so this never underflows.
  assign occupancy_s = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop_s};
  assign issue_s     = (occupancy_s < 3'd2);

  assign O_instr      = fifo_instr_q[rd_ptr_q];
  assign O_pc         = fifo_pc_q[rd_ptr_q];
  assign O_misaligned = misaligned_q;

  // Fetch address: reset forces RESET_PC, a redirect bypasses fpc directly.
  always_comb begin
    O_imem_address = fpc_q;
    if (I_reset) begin
      O_imem_address = RESET_PC;
    end else if (I_redirect) begin
      O_imem_address = target_s;
    end else begin
      O_imem_address = fpc_q;
    end
  end

  // Next-state logic for fetch PC, in-flight tracking and FIFO bookkeeping.
  always_comb begin
    fpc_d         = fpc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    misaligned_d  = 1'b0;
    if (I_redirect) begin
      // Flush buffer, drop the returning word, fetch the aligned target now.
      fpc_d         = target_s + 32'd4;
      inflight_d    = 1'b1;
      inflight_pc_d = target_s;
      rd_ptr_d      = 1'b0;
      wr_ptr_d      = 1'b0;
      count_d       = 2'd0;
      misaligned_d  = (I_redirect_pc[1:0] != 2'b00);
    end else begin
      if (issue_s) begin
        inflight_d    = 1'b1;
        inflight_pc_d = fpc_q;
        fpc_d         = fpc_q + 32'd4;
      end else begin
        inflight_d = 1'b0;
      end
      if (push_s) begin
        wr_ptr_d = ~wr_ptr_q;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = ~rd_ptr_q;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      fpc_q         <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
      misaligned_q  <= 1'b0;
    end else begin
      fpc_q         <= fpc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      misaligned_q  <= misaligned_d;
    end
  end

  // FIFO payload storage; contents are only observed while count is non-zero.
  always_ff @(posedge I_clk) begin
    if (push_s && !I_reset) begin
      fifo_pc_q[wr_ptr_q]    <= inflight_pc_q;
      fifo_instr_q[wr_ptr_q] <= I_imem_data;
    end else begin
      fifo_pc_q[wr_ptr_q]    <= fifo_pc_q[wr_ptr_q];
      fifo_instr_q[wr_ptr_q] <= fifo_instr_q[wr_ptr_q];
    end
  end

  fetch_sequencer_chk u_chk (
    .I_clk   (I_clk),
    .I_reset (I_reset),
    .I_push  (push_s),
    .I_pop   (pop_s),
    .I_count (count_q)
  );

endmodule

// ---------------------------------------------------------------------------
// fetch_sequencer_chk
// Property checker for the fetch buffer: a push may never land on a full
// FIFO unless the head is popped in the same cycle, and count stays <= 2.
// Ports: I_clk, I_reset, I_push, I_pop, I_count (current FIFO occupancy).
// ---------------------------------------------------------------------------
module fetch_sequencer_chk (
  input logic       I_clk,
  input logic       I_reset,
  input logic       I_push,
  input logic       I_pop,
  input logic [1:0] I_count
);

  a_no_overflow: assert property (@(posedge I_clk) disable iff (I_reset)
    !(I_push && (I_count == 2'd2) && !I_pop));

  a_count_range: assert property (@(posedge I_clk) disable iff (I_reset)
    (I_count <= 2'd2));

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer with a behavioural synchronous
// instruction memory. Inputs change 1 time unit after the rising edge and
// outputs are sampled 1 time unit later, well away from the next edge.
module tb_fetch_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        I_clk;
  logic        I_reset;
  logic [31:0] O_imem_address;
  logic [31:0] I_imem_data;
  logic        I_redirect;
  logic [31:0] I_redirect_pc;
  logic        O_valid;
  logic        I_ready;
  logic [31:0] O_instr;
  logic [31:0] O_pc;
  logic        O_misaligned;

  int n_checks;
  int n_errors;

  fetch_sequencer #(.RESET_PC(RST_PC)) dut (
    .I_clk          (I_clk),
    .I_reset        (I_reset),
    .O_imem_address (O_imem_address),
    .I_imem_data    (I_imem_data),
    .I_redirect     (I_redirect),
    .I_redirect_pc  (I_redirect_pc),
    .O_valid        (O_valid),
    .I_ready        (I_ready),
    .O_instr        (O_instr),
    .O_pc           (O_pc),
    .O_misaligned   (O_misaligned)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  // Memory image: three hand-picked words at 0x100.., elsewhere C0DE_<addr[15:0]>.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0100: mem_word = 32'h0000_00A0;
      32'h0000_0104: mem_word = 32'h0000_00A1;
      32'h0000_0108: mem_word = 32'h0000_00A2;
      default:       mem_word = {16'hC0DE, a[15:0]};
    endcase
  endfunction

  // Synchronous memory: data for the sampled address appears next cycle.
  always @(posedge I_clk) I_imem_data <= mem_word(O_imem_address);

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle and apply that cycle's inputs.
  task automatic step(input logic rst, input logic redir, input logic [31:0] rpc, input logic rdy);
    @(posedge I_clk);
    #1;
    I_reset       = rst;
    I_redirect    = redir;
    I_redirect_pc = rpc;
    I_ready       = rdy;
    #1;
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    I_reset       = 1'b1;
    I_redirect    = 1'b0;
    I_redirect_pc = 32'h0;
    I_ready       = 1'b0;

    // Reset state
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    check32("rst_valid", {31'b0, O_valid}, 32'd0);
    check32("rst_mis", {31'b0, O_misaligned}, 32'd0);
    check32("rst_addr", O_imem_address, RST_PC);

    // 1. Sequential fetch from reset
    step(1'b0, 1'b0, 32'h0, 1'b1);             // cycle 0
    check32("seq_c0_valid", {31'b0, O_valid}, 32'd0);
    check32("seq_c0_addr", O_imem_address, 32'h100);
    step(1'b0, 1'b0, 32'h0, 1'b1);             // cycle 1
    check32("seq_c1_valid", {31'b0, O_valid}, 32'd0);
    check32("seq_c1_addr", O_imem_address, 32'h104);
    step(1'b0, 1'b0, 32'h0, 1'b1);             // cycle 2
    check32("seq_c2_valid", {31'b0, O_valid}, 32'd1);
    check32("seq_c2_pc", O_pc, 32'h100);
    check32("seq_c2_instr", O_instr, 32'hA0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check32("seq_c3_pc", O_pc, 32'h104);
    check32("seq_c3_instr", O_instr, 32'hA1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check32("seq_c4_pc", O_pc, 32'h108);
    check32("seq_c4_instr", O_instr, 32'hA2);

    // 2. Backpressure from cycle 2 for 5 cycles
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);             // cycle 0
    step(1'b0, 1'b0, 32'h0, 1'b1);             // cycle 1
    for (int i = 0; i < 5; i++) begin          // cycles 2..6
      step(1'b0, 1'b0, 32'h0, 1'b0);
      check32("bp_valid", {31'b0, O_valid}, 32'd1);
      check32("bp_pc_hold", O_pc, 32'h100);
      check32("bp_instr_hold", O_instr, 32'hA0);
      check32("bp_no_issue_addr", O_imem_address, 32'h108);
    end
    step(1'b0, 1'b0, 32'h0, 1'b1);             // cycle 7
    check32("bp_rel0_pc", O_pc, 32'h100);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check32("bp_rel1_valid", {31'b0, O_valid}, 32'd1);
    check32("bp_rel1_pc", O_pc, 32'h104);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check32("bp_rel2_pc", O_pc, 32'h108);
    check32("bp_rel2_instr", O_instr, 32'hA2);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check32("bp_rel3_pc", O_pc, 32'h10C);
    check32("bp_rel3_instr", O_instr, 32'hC0DE_010C);

    // 3. Redirect with full FIFO
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h40, 1'b1);            // r
    check32("rd_pre_valid", {31'b0, O_valid}, 32'd1);
    check32("rd_addr", O_imem_address, 32'h40);
    step(1'b0, 1'b0, 32'h0, 1'b1);             // r+1
    check32("rd_r1_valid", {31'b0, O_valid}, 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1);             // r+2
    check32("rd_r2_valid", {31'b0, O_valid}, 32'd1);
    check32("rd_r2_pc", O_pc, 32'h40);
    check32("rd_r2_instr", O_instr, 32'hC0DE_0040);
    step(1'b0, 1'b0, 32'h0, 1'b1);             // r+3
    check32("rd_r3_pc", O_pc, 32'h44);

    // 4. Misaligned redirect
    step(1'b0, 1'b1, 32'h46, 1'b1);            // r
    check32("mis_addr", O_imem_address, 32'h44);
    check32("mis_r0", {31'b0, O_misaligned}, 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1);             // r+1
    check32("mis_r1", {31'b0, O_misaligned}, 32'd1);
    check32("mis_r1_valid", {31'b0, O_valid}, 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1);             // r+2
    check32("mis_r2", {31'b0, O_misaligned}, 32'd0);
    check32("mis_r2_pc", O_pc, 32'h44);
    step(1'b0, 1'b0, 32'h0, 1'b1);             // r+3
    check32("mis_r3_pc", O_pc, 32'h48);

    // 5. Wrap-around
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);     // r
    step(1'b0, 1'b0, 32'h0, 1'b1);             // r+1
    step(1'b0, 1'b0, 32'h0, 1'b1);             // r+2
    check32("wrap_pc0", O_pc, 32'hFFFF_FFFC);
    check32("wrap_instr0", O_instr, 32'hC0DE_FFFC);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check32("wrap_pc1", O_pc, 32'h0000_0000);
    check32("wrap_instr1", O_instr, 32'hC0DE_0000);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check32("wrap_pc2", O_pc, 32'h0000_0004);

    // Back-to-back redirects: the second (misaligned) one wins
    step(1'b0, 1'b1, 32'h200, 1'b1);           // r
    step(1'b0, 1'b1, 32'h302, 1'b1);           // r+1
    check32("b2b_r1_valid", {31'b0, O_valid}, 32'd0);
    check32("b2b_r1_addr", O_imem_address, 32'h300);
    step(1'b0, 1'b0, 32'h0, 1'b1);             // r+2
    check32("b2b_r2_valid", {31'b0, O_valid}, 32'd0);
    check32("b2b_r2_mis", {31'b0, O_misaligned}, 32'd1);
    step(1'b0, 1'b0, 32'h0, 1'b1);             // r+3
    check32("b2b_r3_pc", O_pc, 32'h300);
    check32("b2b_r3_mis", {31'b0, O_misaligned}, 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check32("b2b_r4_pc", O_pc, 32'h304);

    // 6. Reset mid-operation (word buffered + word in flight), with a
    //    simultaneous misaligned redirect that reset must override
    step(1'b0, 1'b1, 32'h500, 1'b0);           // r
    step(1'b0, 1'b0, 32'h0, 1'b0);             // r+1
    step(1'b1, 1'b1, 32'h46, 1'b0);            // r+2: reset asserted
    check32("mrst_pre_valid", {31'b0, O_valid}, 32'd1);
    check32("mrst_pre_pc", O_pc, 32'h500);
    check32("mrst_addr", O_imem_address, RST_PC);
    step(1'b0, 1'b0, 32'h0, 1'b1);             // cycle 0
    check32("mrst_c0_valid", {31'b0, O_valid}, 32'd0);
    check32("mrst_c0_mis", {31'b0, O_misaligned}, 32'd0);
    check32("mrst_c0_addr", O_imem_address, RST_PC);
    step(1'b0, 1'b0, 32'h0, 1'b1);             // cycle 1
    check32("mrst_c1_valid", {31'b0, O_valid}, 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1);             // cycle 2
    check32("mrst_c2_pc", O_pc, RST_PC);
    check32("mrst_c2_instr", O_instr, 32'hA0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check32("mrst_c3_pc", O_pc, 32'h104);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
